// File: rtl/interp_fir.sv
// interp_fir: interpolating polyphase FIR filter.
//
// For each input sample popped from the upstream FIFO, the block produces
// INTERPOLATION filtered outputs into the downstream FIFO. This is equivalent
// to zero-stuffing by L followed by a TAPS-tap FIR, but only the non-zero
// products are computed. One multiply-accumulate is performed per cycle.
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-high reset
//   x_in_rd_en   pop strobe to the input FIFO (combinational, LOAD only)
//   x_in_empty   input FIFO empty
//   x_in         input FIFO head data (show-ahead), signed
//   y_out        output sample, signed; driven from the accumulator
//   y_out_wr_en  push strobe to the output FIFO (combinational, WRITE only)
//   y_out_full   output FIFO full
module interp_fir #(
    parameter int INTERPOLATION = 2,
    parameter int TAPS          = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MULT_WIDTH    = 64,
    parameter int FRAC_BITS     = 10,
    parameter logic signed [0:TAPS-1][DATA_WIDTH-1:0] coeff = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  x_in_rd_en,
    input  logic                  x_in_empty,
    input  logic [DATA_WIDTH-1:0] x_in,
    output logic [DATA_WIDTH-1:0] y_out,
    output logic                  y_out_wr_en,
    input  logic                  y_out_full
);

    localparam int P  = TAPS / INTERPOLATION;
    localparam int TW = (P > 1) ? $clog2(P) : 1;
    localparam int PW = (INTERPOLATION > 1) ? $clog2(INTERPOLATION) : 1;
    localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;

    localparam logic [TW-1:0] TAP_LAST = TW'(P - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(INTERPOLATION - 1);

    // Adding 2^FRAC_BITS-1 to negative products before the arithmetic shift
    // makes the shift truncate toward zero, matching signed division.
    localparam logic signed [MULT_WIDTH-1:0] BIAS =
        (MULT_WIDTH'(1) <<< FRAC_BITS) - MULT_WIDTH'(1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] hist [P];
    logic [DATA_WIDTH-1:0] acc;
    logic [PW-1:0]         phase;
    logic [TW-1:0]         tap;

    logic [IW-1:0]                  coef_idx;
    logic [DATA_WIDTH-1:0]          hist_sel;
    logic [DATA_WIDTH-1:0]          coef_sel;
    logic signed [MULT_WIDTH-1:0]   op_a;
    logic signed [MULT_WIDTH-1:0]   op_b;
    logic signed [MULT_WIDTH-1:0]   prod;
    logic signed [MULT_WIDTH-1:0]   prod_adj;
    logic [DATA_WIDTH-1:0]          dq;

    // Polyphase tap selection: phase p uses h[k*L + p] against hist[k].
    always_comb begin
        coef_idx = IW'(tap) * IW'(INTERPOLATION) + IW'(phase);
        hist_sel = hist[tap];
        coef_sel = coeff[coef_idx];
        op_a     = MULT_WIDTH'($signed(hist_sel));
        op_b     = MULT_WIDTH'($signed(coef_sel));
        prod     = op_a * op_b;
        prod_adj = prod + (prod[MULT_WIDTH-1] ? BIAS : '0);
        dq       = DATA_WIDTH'(prod_adj >>> FRAC_BITS);
    end

    // Strobes are gated by rst so they stay low while reset is held,
    // even though the state register already reads LOAD.
    always_comb begin
        state_d     = state_q;
        x_in_rd_en  = 1'b0;
        y_out_wr_en = 1'b0;
        case (state_q)
            LOAD: begin
                if (!x_in_empty && !rst) begin
                    x_in_rd_en = 1'b1;
                    state_d    = MAC;
                end
            end
            MAC: begin
                if (tap == TAP_LAST) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!y_out_full && !rst) begin
                    y_out_wr_en = 1'b1;
                    state_d     = (phase == PH_LAST) ? LOAD : MAC;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist  <= '{default: '0};
            acc   <= '0;
            phase <= '0;
            tap   <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (x_in_rd_en) begin
                        for (int unsigned k = P - 1; k > 0; k--) begin
                            hist[k] <= hist[k-1];
                        end
                        hist[0] <= x_in;
                        phase   <= '0;
                        tap     <= '0;
                        acc     <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + dq;
                    if (tap != TAP_LAST) begin
                        tap <= tap + 1'b1;
                    end
                end
                WRITE: begin
                    if (y_out_wr_en && (phase != PH_LAST)) begin
                        phase <= phase + 1'b1;
                        tap   <= '0;
                        acc   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign y_out = acc;

endmodule

// File: tb/tb_interp_fir.sv
// tb_interp_fir: self-checking bench for interp_fir.
//
// Three instances share one FIFO-side driver, selected by 'sel':
//   A: L=2, TAPS=8, h[j]=(j+1)*1024       (impulse, backpressure, gaps, reset)
//   B: L=2, TAPS=8, h[j]=512              (DC ramp)
//   C: L=1, TAPS=4, h={-1,1024,0,-700}    (truncation toward zero)
// Expected outputs come from fixed vectors and from a plain-arithmetic
// reference model of the convolution.
module tb_interp_fir;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    localparam logic [0:7][31:0] CA = {32'd1024, 32'd2048, 32'd3072, 32'd4096,
                                       32'd5120, 32'd6144, 32'd7168, 32'd8192};
    localparam logic [0:7][31:0] CB = {8{32'd512}};
    localparam logic [0:3][31:0] CC = {-32'sd1, 32'sd1024, 32'sd0, -32'sd700};

    int          sel;
    logic        empty_drv, full_drv;
    logic [31:0] x_drv;

    logic        rd_a, rd_b, rd_c, wr_a, wr_b, wr_c;
    logic [31:0] y_a, y_b, y_c;
    logic        em_a, em_b, em_c, fu_a, fu_b, fu_c;
    logic        rd, wr;
    logic [31:0] y;

    assign em_a = (sel == 0) ? empty_drv : 1'b1;
    assign em_b = (sel == 1) ? empty_drv : 1'b1;
    assign em_c = (sel == 2) ? empty_drv : 1'b1;
    assign fu_a = (sel == 0) ? full_drv : 1'b1;
    assign fu_b = (sel == 1) ? full_drv : 1'b1;
    assign fu_c = (sel == 2) ? full_drv : 1'b1;
    assign rd   = (sel == 0) ? rd_a : (sel == 1) ? rd_b : rd_c;
    assign wr   = (sel == 0) ? wr_a : (sel == 1) ? wr_b : wr_c;
    assign y    = (sel == 0) ? y_a  : (sel == 1) ? y_b  : y_c;

    interp_fir #(.INTERPOLATION(2), .TAPS(8), .DATA_WIDTH(32), .MULT_WIDTH(64),
                 .FRAC_BITS(10), .coeff(CA)) dut_a (
        .clk(clk), .rst(rst), .x_in_rd_en(rd_a), .x_in_empty(em_a), .x_in(x_drv),
        .y_out(y_a), .y_out_wr_en(wr_a), .y_out_full(fu_a));

    interp_fir #(.INTERPOLATION(2), .TAPS(8), .DATA_WIDTH(32), .MULT_WIDTH(64),
                 .FRAC_BITS(10), .coeff(CB)) dut_b (
        .clk(clk), .rst(rst), .x_in_rd_en(rd_b), .x_in_empty(em_b), .x_in(x_drv),
        .y_out(y_b), .y_out_wr_en(wr_b), .y_out_full(fu_b));

    interp_fir #(.INTERPOLATION(1), .TAPS(4), .DATA_WIDTH(32), .MULT_WIDTH(64),
                 .FRAC_BITS(10), .coeff(CC)) dut_c (
        .clk(clk), .rst(rst), .x_in_rd_en(rd_c), .x_in_empty(em_c), .x_in(x_drv),
        .y_out(y_c), .y_out_wr_en(wr_c), .y_out_full(fu_c));

    typedef struct {
        int dut;
        int x;
        int y0;
        int y1;
    } vec_t;

    vec_t vec [17];
    int   cf [3][8];
    int   lv [3] = '{2, 2, 1};
    int   tv [3] = '{8, 8, 4};

    int   total = 0;
    int   bad   = 0;
    int   reads;
    int   src [$];
    int   inq [$];
    int   got [$];
    int   exp_q [$];

    task automatic chk(input string nm, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Direct convolution over the zero-free polyphase taps.
    function automatic void build_model(input int s);
        longint h [8];
        int     acc;
        int     L, P;
        L = lv[s];
        P = tv[s] / L;
        exp_q.delete();
        foreach (h[k]) h[k] = 0;
        foreach (inq[i]) begin
            for (int k = P - 1; k > 0; k--) h[k] = h[k-1];
            h[0] = longint'(inq[i]);
            for (int p = 0; p < L; p++) begin
                acc = 0;
                for (int k = 0; k < P; k++)
                    acc += int'((h[k] * longint'(cf[s][k*L+p])) / 1024);
                exp_q.push_back(acc);
            end
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        empty_drv = 1'b0;
        full_drv  = 1'b0;
        x_drv     = 32'h1234;
        #1;
        chk("rst_rd_en", rd, 0);
        chk("rst_wr_en", wr, 0);
        chk("rst_y", $signed(y), 0);
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        empty_drv = 1'b1;
        full_drv  = 1'b0;
    endtask

    // Feed src to the selected DUT and collect nout outputs. Timing of
    // rd_en/wr_en is checked each cycle against the protocol: a write is
    // due P+1 cycles after a read or the previous write, delayed by the
    // number of full cycles imposed on entering WRITE.
    task automatic run(input int gap, input int stall, input int nout);
        int          L, P, age, gap_cnt, cyc, ph;
        bit          pending;
        logic [31:0] y_hold;
        L = lv[sel]; P = tv[sel] / L;
        age = 0; gap_cnt = 0; cyc = 0; ph = 0; pending = 0; y_hold = '0;
        reads = 0;
        got.delete();
        while (got.size() < nout) begin
            @(negedge clk);
            cyc++;
            age++;
            if (cyc > 3000) begin
                chk("timeout_outputs", got.size(), nout);
                empty_drv = 1'b1;
                return;
            end
            empty_drv = (src.size() == 0) || (gap_cnt > 0);
            x_drv     = (src.size() > 0) ? src[0] : 0;
            full_drv  = pending && (age > P) && (age <= P + stall);
            #1;
            if (!pending && gap_cnt > 0) gap_cnt--;
            chk("rd_en", rd, !pending && !empty_drv);
            chk("wr_en", wr, pending && (age == P + 1 + stall));
            if (pending && stall > 0 && age == P + 1)
                y_hold = y;
            else if (pending && stall > 0 && age > P + 1 && age <= P + 1 + stall)
                chk("y_stable_full", y, y_hold);
            if (rd) begin
                void'(src.pop_front());
                reads++;
                pending = 1; ph = 0; age = 0; gap_cnt = gap;
            end
            if (wr) begin
                got.push_back(y);
                ph++; age = 0;
                if (ph == L) pending = 0;
            end
        end
        empty_drv = 1'b1;
        full_drv  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, idx;
        rst = 1'b1; sel = 0; empty_drv = 1'b1; full_drv = 1'b0; x_drv = '0;
        for (int j = 0; j < 8; j++) begin
            cf[0][j] = int'(CA[j]);
            cf[1][j] = int'(CB[j]);
            cf[2][j] = (j < 4) ? int'(CC[j]) : 0;
        end

        vec[0]  = '{0, 1024, 1024, 2048};
        vec[1]  = '{0, 0, 3072, 4096};
        vec[2]  = '{0, 0, 5120, 6144};
        vec[3]  = '{0, 0, 7168, 8192};
        vec[4]  = '{0, 0, 0, 0};
        vec[5]  = '{0, 0, 0, 0};
        vec[6]  = '{0, 0, 0, 0};
        vec[7]  = '{0, 0, 0, 0};
        vec[8]  = '{1, 1024, 512, 512};
        vec[9]  = '{1, 1024, 1024, 1024};
        vec[10] = '{1, 1024, 1536, 1536};
        vec[11] = '{1, 1024, 2048, 2048};
        vec[12] = '{1, 1024, 2048, 2048};
        vec[13] = '{1, 1024, 2048, 2048};
        vec[14] = '{2, 1023, 0, 0};
        vec[15] = '{2, -2048, 1025, 0};
        vec[16] = '{2, 0, -2048, 0};

        // Fixed vectors: impulse, DC ramp, truncation.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            do_reset();
            src.delete();
            n = 0;
            foreach (vec[i]) if (vec[i].dut == s) begin src.push_back(vec[i].x); n++; end
            run(0, 0, n * lv[s]);
            idx = 0;
            foreach (vec[i]) if (vec[i].dut == s) begin
                chk("vec_y_phase0", got[idx], vec[i].y0); idx++;
                if (lv[s] == 2) begin chk("vec_y_phase1", got[idx], vec[i].y1); idx++; end
            end
            chk("vec_writes", got.size(), n * lv[s]);
            chk("vec_reads", reads, n);
        end

        // Random inputs against the model: plain, output stalls, input gaps.
        for (int s = 0; s < 3; s += 2) begin
            sel = s;
            inq.delete();
            for (int i = 0; i < 6; i++)
                inq.push_back((i % 2 == 1) ? int'($urandom)
                                           : int'($urandom_range(0, 8191)) - 4096);
            build_model(s);
            for (int mode = 0; mode < 3; mode++) begin
                do_reset();
                src = inq;
                run((mode == 2) ? 5 : 0, (mode == 1) ? 10 : 0, exp_q.size());
                foreach (exp_q[i]) chk("model_y", got[i], exp_q[i]);
                chk("model_reads", reads, got.size() / lv[s]);
            end
        end

        // Reset in the middle of phase-1 MAC, then the impulse must reproduce.
        sel = 0;
        do_reset();
        src.delete();
        foreach (vec[i]) if (vec[i].dut == 0) src.push_back(vec[i].x);
        run(0, 0, 1);
        chk("pre_reset_first_y", $signed(got[0]), 1024);
        repeat (2) @(negedge clk);
        rst = 1'b1; empty_drv = 1'b0; full_drv = 1'b0;
        #1;
        chk("midrst_rd_en", rd, 0);
        chk("midrst_wr_en", wr, 0);
        chk("midrst_y", $signed(y), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk("midrst_no_write", wr, 0);
        end
        rst = 1'b0; empty_drv = 1'b1;
        src.delete();
        foreach (vec[i]) if (vec[i].dut == 0) src.push_back(vec[i].x);
        run(0, 0, 16);
        idx = 0;
        foreach (vec[i]) if (vec[i].dut == 0) begin
            chk("postrst_y_phase0", got[idx], vec[i].y0); idx++;
            chk("postrst_y_phase1", got[idx], vec[i].y1); idx++;
        end
        chk("postrst_reads", reads, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interp_fir.md
# interp_fir

Interpolating polyphase FIR filter for the audio/baseband chain. It is the upsampling counterpart of the decimating FIR stage. For every input sample read from an upstream FIFO it produces INTERPOLATION filtered output samples into a downstream FIFO. This is equivalent to zero-stuffing by INTERPOLATION followed by a TAPS-tap FIR, computed without the zero multiplies. One multiply-accumulate is performed per cycle.

## Interface

Parameters:
- INTERPOLATION, 2: upsampling factor L; range 1..16; TAPS must be divisible by L.
- TAPS, 32: total filter length; range up to 128.
- DATA_WIDTH, 32: sample, coefficient and accumulator width, two's complement.
- MULT_WIDTH, 64: product width; ≥ 2·DATA_WIDTH.
- FRAC_BITS, 10: fixed-point fraction bits for samples and coefficients.
- coeff, all zeros: signed [0:TAPS-1][DATA_WIDTH-1:0] impulse response h[0..TAPS-1], h[0] first.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset; asynchronous, active-high.
- x_in_rd_en, output, 1: pop strobe to the input FIFO.
- x_in_empty, input, 1: input FIFO empty.
- x_in, input, DATA_WIDTH: input FIFO head data, signed.
- y_out, output, DATA_WIDTH: output sample, signed.
- y_out_wr_en, output, 1: push strobe to the output FIFO.
- y_out_full, input, 1: output FIFO full.

## Operation

- Let P = TAPS/L, the taps per phase.
- History register hist[0..P-1] holds input samples; hist[0] is the newest.
- Output for phase p (0..L-1) is y = Σ_{k=0..P-1} DQ(hist[k] · coeff[k·L+p]).
- Arithmetic rules:
  - Operands are sign-extended to MULT_WIDTH before multiplying.
  - DQ() is signed division by 2^FRAC_BITS, truncating toward zero (not an arithmetic shift).
  - The DQ result is truncated to DATA_WIDTH.
  - Accumulation is DATA_WIDTH with two's-complement wrap; no saturation.
- No gain compensation for L; any gain is folded into coeff.
- State machine, reset state LOAD:
  - LOAD:
    - When !x_in_empty: x_in_rd_en=1 for that cycle.
    - Shift hist (hist[k]←hist[k-1], hist[0]←x_in).
    - Set phase=0, tap=0, acc=0, then go to MAC.
    - When empty: stay, rd_en=0.
  - MAC:
    - Each cycle: acc += DQ(hist[tap]·coeff[tap·L+phase]), then tap++.
    - After the tap=P-1 product is accumulated, go to WRITE.
    - Always P cycles.
  - WRITE:
    - When !y_out_full: y_out_wr_en=1 for that cycle.
    - If phase==L-1, go to LOAD.
    - Otherwise phase++, tap=0, acc=0, and go to MAC.
    - When full: stay, wr_en=0, acc held.
- y_out is driven from the acc register at all times; it is meaningful only when y_out_wr_en=1.
- hist persists across input samples and is cleared only by reset.
- Exactly one input is read per L outputs. Inputs are never dropped, and outputs are never duplicated or skipped.

## Timing

- Reset (async assert):
  - state=LOAD; hist, acc, phase, tap = 0.
  - y_out=0.
  - x_in_rd_en=0 and y_out_wr_en=0 while rst=1, regardless of empty/full.
- Reset mid-operation aborts the current sample. Partial outputs are not emitted. After deassertion the block starts fresh in LOAD.
- x_in_rd_en and y_out_wr_en are combinational, asserted only in LOAD and WRITE respectively. They are never asserted in the same cycle.
- x_in is sampled in the same cycle rd_en is asserted (FIFO show-ahead).
- Latency: input read at cycle t gives the first output wr_en at cycle t+1+P when there is no backpressure. Each subsequent phase follows 1+P cycles later.
- Unstalled throughput: one input per L·(P+1)+1 = TAPS+L+1 cycles.
- Stalls:
  - Input empty stalls in LOAD only.
  - Output full stalls in WRITE only; wr_en is issued in the first cycle full=0.

## Test plan

- Impulse test:
  - Setup: L=2, TAPS=8, FRAC_BITS=10, coeff[j]=(j+1)·1024. Input 1024 then seven zeros.
  - Required: outputs 1024,2048,3072,4096,5120,6144,7168,8192, then 0 ×8.
  - Required: exactly 16 writes and 8 reads.
- DC test:
  - Setup: L=2, TAPS=8, all coeff=512, constant input 1024.
  - Required: phase outputs ramp 512,512,1024,1024,1536,1536, then settle at 2048 for every output from the 4th input onward.
- Truncation test:
  - Setup: coeff[0]=-1, others 0, L=1, TAPS=4; input 1023.
  - Required: y=0, not -1.
  - Input -2048 with coeff[0]=1024 gives y=-2048.
- Backpressure test:
  - Stimulus: hold y_out_full=1 for 10 cycles on entering WRITE.
  - Required: wr_en=0 and y_out stable throughout; a single write in the release cycle; output sequence identical to the unstalled run.
- Empty-stall test:
  - Stimulus: insert 5-cycle empty gaps between inputs.
  - Required: no rd_en while empty; output sequence unchanged; read count = writes/L.
- Reset test:
  - Stimulus: assert rst during MAC of phase 1.
  - Required: rd_en, wr_en and y_out go to 0 immediately; no partial write.
  - Required: after release, the impulse test reproduces exactly, confirming hist was cleared.
